// File: rtl/reg_bank_arbiter.sv
// Round-robin arbiter sharing one register-bank port between requester A (SPI) and requester B (I2C).
// Each access runs IDLE -> ACCESS -> [WAIT] -> RESP. An out-of-range address skips the bank and goes straight to RESP.
module reg_bank_arbiter #(
    parameter int REG_W    = 8,
    parameter int NUM_REGS = 8
) (
    input  logic             clk,
    input  logic             rstb,
    input  logic             ena,
    input  logic             a_req,
    input  logic             a_wr,
    input  logic [REG_W-2:0] a_addr,
    input  logic [REG_W-1:0] a_wdata,
    output logic             a_ack,
    output logic             a_err,
    output logic [REG_W-1:0] a_rdata,
    input  logic             b_req,
    input  logic             b_wr,
    input  logic [REG_W-2:0] b_addr,
    input  logic [REG_W-1:0] b_wdata,
    output logic             b_ack,
    output logic             b_err,
    output logic [REG_W-1:0] b_rdata,
    output logic [REG_W-2:0] bank_addr,
    output logic [REG_W-1:0] bank_wdata,
    output logic             bank_we,
    output logic             bank_re,
    input  logic [REG_W-1:0] bank_rdata,
    output logic             busy
);
    localparam int   AW    = REG_W - 1;
    localparam logic GNT_A = 1'b0;
    localparam logic GNT_B = 1'b1;

    typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} state_t;

    state_t           state_reg;
    state_t           state_next;
    logic             winner_reg;
    logic             last_gnt_reg;
    logic             wr_reg;
    logic             err_reg;
    logic [AW-1:0]    addr_reg;
    logic [REG_W-1:0] wdata_reg;

    logic [1:0]       req_vec;
    logic [1:0]       wr_vec;
    logic [1:0]       ack_vec;
    logic [1:0]       err_vec;
    logic [AW-1:0]    addr_arr  [2];
    logic [REG_W-1:0] wdata_arr [2];

    logic             start;
    logic             pick;
    logic             sel_err;

    assign req_vec      = {b_req, a_req};
    assign wr_vec       = {b_wr, a_wr};
    assign addr_arr[0]  = a_addr;
    assign addr_arr[1]  = b_addr;
    assign wdata_arr[0] = a_wdata;
    assign wdata_arr[1] = b_wdata;

    assign start   = (state_reg == IDLE) && (|req_vec);
    // B wins when it asks alone, or when both ask and A was the last one served.
    assign pick    = req_vec[1] && (!req_vec[0] || (last_gnt_reg == GNT_A));
    assign sel_err = 32'(addr_arr[pick]) >= 32'(NUM_REGS);

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state_reg <= IDLE;
        end else if (ena) begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (|req_vec) state_next = sel_err ? RESP : ACCESS;
            ACCESS:  state_next = wr_reg ? RESP : WAIT;
            WAIT:    state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            winner_reg   <= GNT_A;
            last_gnt_reg <= GNT_B;
            wr_reg       <= 1'b0;
            err_reg      <= 1'b0;
            addr_reg     <= '0;
            wdata_reg    <= '0;
        end else if (ena) begin
            if (start) begin
                winner_reg <= pick;
                wr_reg     <= wr_vec[pick];
                addr_reg   <= addr_arr[pick];
                wdata_reg  <= wdata_arr[pick];
                err_reg    <= sel_err;
            end
            if (state_reg == RESP) begin
                last_gnt_reg <= winner_reg;
            end
        end
    end

    // Per-requester read-data holding registers; an out-of-range read clears the owner's copy.
    for (genvar gi = 0; gi < 2; gi++) begin : g_req
        logic [REG_W-1:0] rdata_reg;

        always_ff @(posedge clk or negedge rstb) begin
            if (!rstb) begin
                rdata_reg <= '0;
            end else if (ena) begin
                if ((state_reg == WAIT) && (winner_reg == 1'(gi))) begin
                    rdata_reg <= bank_rdata;
                end else if (start && (pick == 1'(gi)) && sel_err && !wr_vec[gi]) begin
                    rdata_reg <= '0;
                end
            end
        end
    end

    always_comb begin
        bank_addr  = '0;
        bank_wdata = '0;
        bank_we    = 1'b0;
        bank_re    = 1'b0;
        ack_vec    = '0;
        err_vec    = '0;
        case (state_reg)
            ACCESS: begin
                bank_addr  = addr_reg;
                bank_wdata = wdata_reg;
                bank_we    = wr_reg;
                bank_re    = !wr_reg;
            end
            RESP: begin
                ack_vec[winner_reg] = 1'b1;
                err_vec[winner_reg] = err_reg;
            end
            default: ;
        endcase
    end

    assign busy    = (state_reg != IDLE);
    assign a_ack   = ack_vec[0];
    assign a_err   = err_vec[0];
    assign b_ack   = ack_vec[1];
    assign b_err   = err_vec[1];
    assign a_rdata = g_req[0].rdata_reg;
    assign b_rdata = g_req[1].rdata_reg;

endmodule

// File: tb/tb_reg_bank_arbiter.sv
// Scoreboard bench for reg_bank_arbiter: expected acks are queued at stimulus time,
// observed acks are queued by a monitor, and both are compared at the end.
module tb_reg_bank_arbiter;
    localparam int REG_W    = 8;
    localparam int NUM_REGS = 8;

    typedef struct packed {
        logic        who;
        logic        err;
        logic [7:0]  rdata;
        logic [31:0] cyc;
    } txn_t;

    logic       clk;
    logic       rstb;
    logic       ena;
    logic       a_req, a_wr, a_ack, a_err;
    logic [6:0] a_addr;
    logic [7:0] a_wdata, a_rdata;
    logic       b_req, b_wr, b_ack, b_err;
    logic [6:0] b_addr;
    logic [7:0] b_wdata, b_rdata;
    logic [6:0] bank_addr;
    logic [7:0] bank_wdata, bank_rdata;
    logic       bank_we, bank_re, busy;

    logic [7:0]  mem [0:127];
    logic [37:0] all_out;
    int          cnt    = 0;
    int          we_cnt = 0;
    int          we_lvl = 0;
    int          re_lvl = 0;
    int          n_cmp;
    int          n_bad;
    txn_t        exp_q[$];
    txn_t        obs_q[$];
    logic [7:0]  exp_a_rdata;
    logic [7:0]  exp_b_rdata;

    reg_bank_arbiter #(
        .REG_W    (REG_W),
        .NUM_REGS (NUM_REGS)
    ) dut (
        .clk        (clk),
        .rstb       (rstb),
        .ena        (ena),
        .a_req      (a_req),
        .a_wr       (a_wr),
        .a_addr     (a_addr),
        .a_wdata    (a_wdata),
        .a_ack      (a_ack),
        .a_err      (a_err),
        .a_rdata    (a_rdata),
        .b_req      (b_req),
        .b_wr       (b_wr),
        .b_addr     (b_addr),
        .b_wdata    (b_wdata),
        .b_ack      (b_ack),
        .b_err      (b_err),
        .b_rdata    (b_rdata),
        .bank_addr  (bank_addr),
        .bank_wdata (bank_wdata),
        .bank_we    (bank_we),
        .bank_re    (bank_re),
        .bank_rdata (bank_rdata),
        .busy       (busy)
    );

    assign all_out = {a_ack, a_err, a_rdata, b_ack, b_err, b_rdata,
                      bank_addr, bank_wdata, bank_we, bank_re, busy};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cnt <= cnt + 1;

    // Register bank model, clocked by the same enable as the arbiter.
    always @(posedge clk) begin
        if (ena) begin
            if (bank_we) begin
                mem[bank_addr] <= bank_wdata;
                we_cnt         <= we_cnt + 1;
            end
            if (bank_re) bank_rdata <= mem[bank_addr];
        end
    end

    always @(negedge clk) begin
        if (rstb) begin
            if (a_ack) begin
                obs_q.push_back('{1'b0, a_err, a_rdata, 32'(cnt)});
                $display("ack A err=%0d rdata=%02h cyc=%0d", a_err, a_rdata, cnt);
            end
            if (b_ack) begin
                obs_q.push_back('{1'b1, b_err, b_rdata, 32'(cnt)});
                $display("ack B err=%0d rdata=%02h cyc=%0d", b_err, b_rdata, cnt);
            end
        end
        if (bank_we) we_lvl <= we_lvl + 1;
        if (bank_re) re_lvl <= re_lvl + 1;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
        $fatal(1, "watchdog expired");
    end

    // Drives one request, waits (bounded) for its ack, then drops req on the edge ending the ack cycle.
    task automatic issue(input bit who, input bit wr, input logic [6:0] addr,
                         input logic [7:0] wdata, output bit timed_out);
        bit got;
        got = 1'b0;
        if (!who) begin
            a_wr = wr; a_addr = addr; a_wdata = wdata; a_req = 1'b1;
        end else begin
            b_wr = wr; b_addr = addr; b_wdata = wdata; b_req = 1'b1;
        end
        for (int i = 0; i < 30 && !got; i++) begin
            @(negedge clk);
            got = who ? b_ack : a_ack;
        end
        @(posedge clk);
        #1;
        if (!who) a_req = 1'b0;
        else      b_req = 1'b0;
        timed_out = !got;
    endtask

    task automatic gap();
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if (all_out !== '0) begin
            n_bad++;
            $display("FAIL reset_outputs: got %h, want 0", all_out);
        end
        rstb = 1'b1;
        @(posedge clk);
        #1;
        n_cmp++;
        if (all_out !== '0) begin
            n_bad++;
            $display("FAIL post_reset_idle: got %h, want 0", all_out);
        end
    endtask

    task automatic test_arbitration();
        bit to_a, to_b;
        int k;
        k = cnt;
        exp_q.push_back('{1'b0, 1'b0, exp_a_rdata, 32'(k + 2)});
        exp_q.push_back('{1'b1, 1'b0, exp_b_rdata, 32'(k + 5)});
        fork
            issue(1'b0, 1'b1, 7'd1, 8'h11, to_a);
            issue(1'b1, 1'b1, 7'd2, 8'h22, to_b);
        join
        n_cmp++;
        if (to_a || to_b) begin
            n_bad++;
            $display("FAIL arb_round1_timeout: a=%0d b=%0d, want 0 0", to_a, to_b);
        end
        gap();
        k = cnt;
        exp_q.push_back('{1'b0, 1'b0, exp_a_rdata, 32'(k + 2)});
        issue(1'b0, 1'b1, 7'd4, 8'h44, to_a);
        gap();
        // A was served last, so B now wins the tie.
        k = cnt;
        exp_q.push_back('{1'b1, 1'b0, exp_b_rdata, 32'(k + 2)});
        exp_q.push_back('{1'b0, 1'b0, exp_a_rdata, 32'(k + 5)});
        fork
            issue(1'b0, 1'b1, 7'd1, 8'h91, to_a);
            issue(1'b1, 1'b1, 7'd2, 8'hA2, to_b);
        join
        n_cmp++;
        if (to_a || to_b) begin
            n_bad++;
            $display("FAIL arb_round2_timeout: a=%0d b=%0d, want 0 0", to_a, to_b);
        end
        gap();
    endtask

    task automatic test_write_a();
        bit to_a;
        int k, w0;
        k  = cnt;
        w0 = we_cnt;
        exp_q.push_back('{1'b0, 1'b0, exp_a_rdata, 32'(k + 2)});
        fork
            issue(1'b0, 1'b1, 7'd3, 8'h5A, to_a);
            begin
                @(negedge clk);
                @(negedge clk);
                n_cmp++;
                if ({bank_we, bank_re, bank_addr, bank_wdata} !== {1'b1, 1'b0, 7'd3, 8'h5A}) begin
                    n_bad++;
                    $display("FAIL write_strobe: got we=%0d re=%0d addr=%0d wdata=%02h, want we=1 re=0 addr=3 wdata=5a",
                             bank_we, bank_re, bank_addr, bank_wdata);
                end
            end
        join
        n_cmp++;
        if (we_cnt !== w0 + 1) begin
            n_bad++;
            $display("FAIL write_count: got %0d bank writes, want 1", we_cnt - w0);
        end
        gap();
    endtask

    task automatic test_read_b();
        bit to_b;
        int k;
        k = cnt;
        exp_b_rdata = 8'h5A;
        exp_q.push_back('{1'b1, 1'b0, exp_b_rdata, 32'(k + 3)});
        fork
            issue(1'b1, 1'b0, 7'd3, 8'h00, to_b);
            begin
                @(negedge clk);
                @(negedge clk);
                n_cmp++;
                if ({bank_re, bank_we, bank_addr} !== {1'b1, 1'b0, 7'd3}) begin
                    n_bad++;
                    $display("FAIL read_strobe: got re=%0d we=%0d addr=%0d, want re=1 we=0 addr=3",
                             bank_re, bank_we, bank_addr);
                end
            end
        join
        gap();
        n_cmp++;
        if (b_rdata !== 8'h5A || a_rdata !== exp_a_rdata) begin
            n_bad++;
            $display("FAIL read_hold: got b_rdata=%02h a_rdata=%02h, want b_rdata=5a a_rdata=%02h",
                     b_rdata, a_rdata, exp_a_rdata);
        end
    endtask

    task automatic test_error();
        bit to;
        int k, wl, rl;
        k = cnt;
        exp_a_rdata = 8'h5A;
        exp_q.push_back('{1'b0, 1'b0, exp_a_rdata, 32'(k + 3)});
        issue(1'b0, 1'b0, 7'd3, 8'h00, to);
        gap();
        wl = we_lvl;
        rl = re_lvl;
        k  = cnt;
        exp_a_rdata = 8'h00;
        exp_q.push_back('{1'b0, 1'b1, exp_a_rdata, 32'(k + 1)});
        issue(1'b0, 1'b0, 7'd9, 8'h00, to);
        gap();
        k = cnt;
        exp_q.push_back('{1'b1, 1'b1, exp_b_rdata, 32'(k + 1)});
        issue(1'b1, 1'b1, 7'd8, 8'hEE, to);
        gap();
        n_cmp++;
        if (we_lvl !== wl || re_lvl !== rl) begin
            n_bad++;
            $display("FAIL err_no_strobe: got we_cycles=%0d re_cycles=%0d, want 0 0", we_lvl - wl, re_lvl - rl);
        end
        k = cnt;
        exp_q.push_back('{1'b0, 1'b0, exp_a_rdata, 32'(k + 2)});
        issue(1'b0, 1'b1, 7'd7, 8'h77, to);
        gap();
    endtask

    task automatic test_ena_stall();
        bit to;
        int k, w0, wl;
        k  = cnt;
        w0 = we_cnt;
        wl = we_lvl;
        exp_q.push_back('{1'b0, 1'b0, exp_a_rdata, 32'(k + 5)});
        fork
            issue(1'b0, 1'b1, 7'd5, 8'hC3, to);
            begin
                @(posedge clk);
                #1;
                ena = 1'b0;
                repeat (3) @(posedge clk);
                #1;
                n_cmp++;
                if ({bank_we, bank_addr, bank_wdata, busy} !== {1'b1, 7'd5, 8'hC3, 1'b1}) begin
                    n_bad++;
                    $display("FAIL ena_hold: got we=%0d addr=%0d wdata=%02h busy=%0d, want we=1 addr=5 wdata=c3 busy=1",
                             bank_we, bank_addr, bank_wdata, busy);
                end
                ena = 1'b1;
            end
        join
        n_cmp++;
        if (we_cnt !== w0 + 1 || we_lvl !== wl + 4) begin
            n_bad++;
            $display("FAIL ena_single_write: got writes=%0d we_cycles=%0d, want writes=1 we_cycles=4",
                     we_cnt - w0, we_lvl - wl);
        end
        gap();
    endtask

    task automatic test_reset_mid();
        bit to_a, to_b;
        int k, n_obs;
        a_wr = 1'b0; a_addr = 7'd3; a_req = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if (busy !== 1'b1 || bank_re !== 1'b0) begin
            n_bad++;
            $display("FAIL mid_wait_state: got busy=%0d re=%0d, want busy=1 re=0", busy, bank_re);
        end
        n_obs = obs_q.size();
        rstb  = 1'b0;
        a_req = 1'b0;
        #1;
        n_cmp++;
        if (all_out !== '0) begin
            n_bad++;
            $display("FAIL mid_reset_outputs: got %h, want 0", all_out);
        end
        repeat (2) @(posedge clk);
        #1;
        rstb = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if (obs_q.size() !== n_obs) begin
            n_bad++;
            $display("FAIL mid_reset_no_ack: got %0d acks, want 0", obs_q.size() - n_obs);
        end
        exp_a_rdata = 8'h00;
        exp_b_rdata = 8'h00;
        k = cnt;
        exp_q.push_back('{1'b0, 1'b0, exp_a_rdata, 32'(k + 2)});
        exp_q.push_back('{1'b1, 1'b0, exp_b_rdata, 32'(k + 5)});
        fork
            issue(1'b0, 1'b1, 7'd6, 8'h66, to_a);
            issue(1'b1, 1'b1, 7'd7, 8'h7B, to_b);
        join
        gap();
        k = cnt;
        exp_b_rdata = 8'h66;
        exp_q.push_back('{1'b1, 1'b0, exp_b_rdata, 32'(k + 3)});
        issue(1'b1, 1'b0, 7'd6, 8'h00, to_b);
        gap();
    endtask

    task automatic test_scoreboard();
        txn_t e, o;
        int   idx;
        idx = 0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_cmp++;
            if (obs_q.size() == 0) begin
                n_bad++;
                $display("FAIL sb[%0d] missing: got no ack, want who=%0d err=%0d rdata=%02h cyc=%0d",
                         idx, e.who, e.err, e.rdata, e.cyc);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin
                    n_bad++;
                    $display("FAIL sb[%0d]: got who=%0d err=%0d rdata=%02h cyc=%0d, want who=%0d err=%0d rdata=%02h cyc=%0d",
                             idx, o.who, o.err, o.rdata, o.cyc, e.who, e.err, e.rdata, e.cyc);
                end
            end
            idx++;
        end
        n_cmp++;
        if (obs_q.size() != 0) begin
            n_bad++;
            $display("FAIL sb_extra: got %0d unexpected acks, want 0", obs_q.size());
        end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        exp_a_rdata = 8'h00;
        exp_b_rdata = 8'h00;
        rstb  = 1'b0;
        ena   = 1'b1;
        a_req = 1'b0; a_wr = 1'b0; a_addr = '0; a_wdata = '0;
        b_req = 1'b0; b_wr = 1'b0; b_addr = '0; b_wdata = '0;
        test_reset();
        test_arbitration();
        test_write_a();
        test_read_b();
        test_error();
        test_ena_stall();
        test_reset_mid();
        test_scoreboard();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
